// File: rtl/ysyx_25030081_seq_pkg.sv
// Shared types for the multi-cycle sequencer.
// State encoding and counter width default.
package ysyx_25030081_seq_pkg;

  localparam int CNT_W_DEF = 64;

  typedef enum logic [2:0] {
    S_IF_REQ  = 3'd0,
    S_IF_WAIT = 3'd1,
    S_EX      = 3'd2,
    S_LS_REQ  = 3'd3,
    S_LS_WAIT = 3'd4,
    S_WB      = 3'd5,
    S_HALT    = 3'd6,
    S_TRAP    = 3'd7
  } state_e;

endpackage

// File: rtl/ysyx_25030081_perf_cnt.sv
// Free-running performance counter.
// Counts while enabled, wraps silently.
module ysyx_25030081_perf_cnt #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_d;
  logic [W-1:0] cnt_q;

  // Next count: increment when enabled, else hold.
  always_comb begin
    cnt_d = cnt_q;
    if (en) cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
  end

  // Counter register with async clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/ysyx_25030081_seq.sv
// Multi-cycle instruction sequencer.
// Walks IF -> EX -> [LS] -> WB, parks on ebreak or fault.
module ysyx_25030081_seq
  import ysyx_25030081_seq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             ifu_req_valid,
  input  logic             ifu_req_ready,
  input  logic             ifu_rsp_valid,
  input  logic             ifu_rsp_err,
  output logic             ifu_rsp_ready,
  output logic             ir_we,
  input  logic             dec_mem_ren,
  input  logic             dec_mem_wen,
  input  logic             dec_reg_wr,
  input  logic             dec_ebreak,
  output logic             lsu_req_valid,
  output logic             lsu_req_wen,
  input  logic             lsu_req_ready,
  input  logic             lsu_rsp_valid,
  input  logic             lsu_rsp_err,
  output logic             lsu_rsp_ready,
  output logic             rf_we,
  output logic             pc_we,
  output logic             halted,
  output logic             trapped,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  state_e state_d, state_q;
  logic   mem_ren_d, mem_ren_q;
  logic   mem_wen_d, mem_wen_q;
  logic   reg_wr_d, reg_wr_q;

  // Next-state logic; responses only sampled in WAIT states.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IF_REQ:
        if (ifu_req_ready) state_d = S_IF_WAIT;
      S_IF_WAIT:
        if (ifu_rsp_valid)
          state_d = ifu_rsp_err ? S_TRAP : S_EX;
      S_EX:
        if (dec_ebreak)                    state_d = S_HALT;
        else if (dec_mem_ren && dec_mem_wen) state_d = S_TRAP;
        else if (dec_mem_ren || dec_mem_wen) state_d = S_LS_REQ;
        else                               state_d = S_WB;
      S_LS_REQ:
        if (lsu_req_ready) state_d = S_LS_WAIT;
      S_LS_WAIT:
        if (lsu_rsp_valid)
          state_d = lsu_rsp_err ? S_TRAP : S_WB;
      S_WB:
        state_d = S_IF_REQ;
      S_HALT, S_TRAP:
        state_d = state_q;
    endcase
  end

  // Capture decoder controls during the single EX cycle.
  always_comb begin
    mem_ren_d = mem_ren_q;
    mem_wen_d = mem_wen_q;
    reg_wr_d  = reg_wr_q;
    if (state_q == S_EX) begin
      mem_ren_d = dec_mem_ren;
      mem_wen_d = dec_mem_wen;
      reg_wr_d  = dec_reg_wr;
    end
  end

  // State and latched-control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IF_REQ;
      mem_ren_q <= 1'b0;
      mem_wen_q <= 1'b0;
      reg_wr_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      mem_ren_q <= mem_ren_d;
      mem_wen_q <= mem_wen_d;
      reg_wr_q  <= reg_wr_d;
    end
  end

  // A latched load+store never reaches LS_REQ; treat it as a load.
  assign ifu_req_valid = (state_q == S_IF_REQ);
  assign ifu_rsp_ready = (state_q == S_IF_WAIT);
  assign ir_we         = (state_q == S_IF_WAIT)
                       & ifu_rsp_valid & ~ifu_rsp_err;
  assign lsu_req_valid = (state_q == S_LS_REQ);
  assign lsu_req_wen   = (state_q == S_LS_REQ)
                       & mem_wen_q & ~mem_ren_q;
  assign lsu_rsp_ready = (state_q == S_LS_WAIT);
  assign rf_we         = (state_q == S_WB) & reg_wr_q;
  assign pc_we         = (state_q == S_WB);
  assign halted        = (state_q == S_HALT);
  assign trapped       = (state_q == S_TRAP);

  logic cyc_en;
  assign cyc_en = ~halted & ~trapped;

  ysyx_25030081_perf_cnt #(.W(CNT_W)) u_cycle (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (cyc_en),
    .cnt   (cycle_cnt)
  );

  ysyx_25030081_perf_cnt #(.W(CNT_W)) u_instret (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pc_we),
    .cnt   (instret_cnt)
  );

endmodule

// File: tb/tb_ysyx_25030081_seq.sv
// Directed bench for the sequencer.
// Second instance with 4-bit counters checks wrap.
module tb_ysyx_25030081_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic ifu_req_ready, ifu_rsp_valid, ifu_rsp_err;
  logic dec_mem_ren, dec_mem_wen, dec_reg_wr, dec_ebreak;
  logic lsu_req_ready, lsu_rsp_valid, lsu_rsp_err;

  logic ifu_req_valid, ifu_rsp_ready, ir_we;
  logic lsu_req_valid, lsu_req_wen, lsu_rsp_ready;
  logic rf_we, pc_we, halted, trapped;
  logic [63:0] cycle_cnt, instret_cnt;

  logic w4_ifu_req_valid, w4_ifu_rsp_ready, w4_ir_we;
  logic w4_lsu_req_valid, w4_lsu_req_wen, w4_lsu_rsp_ready;
  logic w4_rf_we, w4_pc_we, w4_halted, w4_trapped;
  logic [3:0] w4_cycle_cnt, w4_instret_cnt;

  ysyx_25030081_seq dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_err(ifu_rsp_err),
    .ifu_rsp_ready(ifu_rsp_ready), .ir_we(ir_we),
    .dec_mem_ren(dec_mem_ren), .dec_mem_wen(dec_mem_wen),
    .dec_reg_wr(dec_reg_wr), .dec_ebreak(dec_ebreak),
    .lsu_req_valid(lsu_req_valid), .lsu_req_wen(lsu_req_wen),
    .lsu_req_ready(lsu_req_ready), .lsu_rsp_valid(lsu_rsp_valid),
    .lsu_rsp_err(lsu_rsp_err), .lsu_rsp_ready(lsu_rsp_ready),
    .rf_we(rf_we), .pc_we(pc_we), .halted(halted), .trapped(trapped),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  ysyx_25030081_seq #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(w4_ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_err(ifu_rsp_err),
    .ifu_rsp_ready(w4_ifu_rsp_ready), .ir_we(w4_ir_we),
    .dec_mem_ren(dec_mem_ren), .dec_mem_wen(dec_mem_wen),
    .dec_reg_wr(dec_reg_wr), .dec_ebreak(dec_ebreak),
    .lsu_req_valid(w4_lsu_req_valid), .lsu_req_wen(w4_lsu_req_wen),
    .lsu_req_ready(lsu_req_ready), .lsu_rsp_valid(lsu_rsp_valid),
    .lsu_rsp_err(lsu_rsp_err), .lsu_rsp_ready(w4_lsu_rsp_ready),
    .rf_we(w4_rf_we), .pc_we(w4_pc_we), .halted(w4_halted),
    .trapped(w4_trapped),
    .cycle_cnt(w4_cycle_cnt), .instret_cnt(w4_instret_cnt)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    ifu_req_ready = 0; ifu_rsp_valid = 0; ifu_rsp_err = 0;
    dec_mem_ren = 0; dec_mem_wen = 0; dec_reg_wr = 0; dec_ebreak = 0;
    lsu_req_ready = 0; lsu_rsp_valid = 0; lsu_rsp_err = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    clr();
    #1;
    chk("rst_ifu_req_valid", ifu_req_valid, 1);
    chk("rst_cycle", cycle_cnt, 0);
    chk("rst_instret", instret_cnt, 0);
    cyc();
    rst_n = 1;
  endtask

  // Zero-wait fetch: IF_REQ then IF_WAIT, ends in EX.
  task automatic fetch();
    ifu_req_ready = 1;
    #1;
    chk("f_req_valid", ifu_req_valid, 1);
    cyc();
    clr();
    ifu_rsp_valid = 1;
    #1;
    chk("f_ir_we", ir_we, 1);
    cyc();
    clr();
  endtask

  task automatic alu_instr();
    fetch();
    dec_reg_wr = 1;
    cyc();
    clr();
    #1;
    chk("alu_pc_we", pc_we, 1);
    cyc();
  endtask

  initial begin
    rst_n = 0;
    clr();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_halted", halted, 0);
    chk("reset_trapped", trapped, 0);
    chk("reset_rf_we", rf_we, 0);
    chk("reset_lsu_valid", lsu_req_valid, 0);
    rst_n = 1;

    // ADD, zero-wait
    ifu_req_ready = 1;
    #1;
    chk("add_c1_req_valid", ifu_req_valid, 1);
    chk("add_c1_ir_we", ir_we, 0);
    cyc();
    clr();
    ifu_rsp_valid = 1;
    #1;
    chk("add_c2_ir_we", ir_we, 1);
    chk("add_c2_rsp_ready", ifu_rsp_ready, 1);
    cyc();
    clr();
    dec_reg_wr = 1;
    #1;
    chk("add_c3_rf_we", rf_we, 0);
    chk("add_c3_pc_we", pc_we, 0);
    cyc();
    clr();
    #1;
    chk("add_c4_rf_we", rf_we, 1);
    chk("add_c4_pc_we", pc_we, 1);
    cyc();
    chk("add_cycle", cycle_cnt, 4);
    chk("add_instret", instret_cnt, 1);
    chk("add_back_if", ifu_req_valid, 1);

    // LW: req ready after 3 waits, response after 2 waits
    fetch();
    dec_mem_ren = 1;
    dec_reg_wr = 1;
    cyc();
    clr();
    for (int i = 0; i < 4; i++) begin
      lsu_req_ready = (i == 3);
      #1;
      chk("lw_req_valid", lsu_req_valid, 1);
      chk("lw_req_wen", lsu_req_wen, 0);
      cyc();
    end
    clr();
    for (int i = 0; i < 3; i++) begin
      lsu_rsp_valid = (i == 2);
      #1;
      chk("lw_rsp_ready", lsu_rsp_ready, 1);
      chk("lw_wait_req_valid", lsu_req_valid, 0);
      cyc();
    end
    clr();
    #1;
    chk("lw_rf_we", rf_we, 1);
    chk("lw_pc_we", pc_we, 1);
    cyc();
    chk("lw_cycle", cycle_cnt, 15);
    chk("lw_instret", instret_cnt, 2);

    // SW
    fetch();
    dec_mem_wen = 1;
    cyc();
    clr();
    lsu_req_ready = 1;
    #1;
    chk("sw_req_valid", lsu_req_valid, 1);
    chk("sw_req_wen", lsu_req_wen, 1);
    cyc();
    clr();
    lsu_rsp_valid = 1;
    #1;
    chk("sw_rsp_ready", lsu_rsp_ready, 1);
    cyc();
    clr();
    #1;
    chk("sw_rf_we", rf_we, 0);
    chk("sw_pc_we", pc_we, 1);
    cyc();
    chk("sw_cycle", cycle_cnt, 21);
    chk("sw_instret", instret_cnt, 3);

    // EBREAK, with spurious traffic while halted
    fetch();
    dec_ebreak = 1;
    dec_reg_wr = 1;
    cyc();
    clr();
    ifu_req_ready = 1; ifu_rsp_valid = 1;
    lsu_req_ready = 1; lsu_rsp_valid = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("eb_halted", halted, 1);
      chk("eb_trapped", trapped, 0);
      chk("eb_pc_we", pc_we, 0);
      chk("eb_rf_we", rf_we, 0);
      chk("eb_ir_we", ir_we, 0);
      chk("eb_req_valid", ifu_req_valid | lsu_req_valid, 0);
      chk("eb_cycle", cycle_cnt, 24);
      chk("eb_instret", instret_cnt, 3);
      cyc();
    end

    // Fetch bus error
    do_reset();
    chk("err_post_rst_halted", halted, 0);
    ifu_req_ready = 1;
    cyc();
    clr();
    ifu_rsp_valid = 1;
    ifu_rsp_err = 1;
    #1;
    chk("err_ir_we", ir_we, 0);
    cyc();
    clr();
    chk("err_trapped", trapped, 1);
    chk("err_halted", halted, 0);
    for (int i = 0; i < 20; i++) begin
      ifu_req_ready = 1; lsu_rsp_valid = 1;
      #1;
      chk("err_ifu_valid", ifu_req_valid, 0);
      chk("err_lsu_valid", lsu_req_valid, 0);
      chk("err_readies", ifu_rsp_ready | lsu_rsp_ready, 0);
      chk("err_cycle", cycle_cnt, 2);
      cyc();
    end
    clr();

    // Reset pulse in LS_WAIT
    do_reset();
    fetch();
    dec_mem_ren = 1;
    cyc();
    clr();
    lsu_req_ready = 1;
    cyc();
    clr();
    #1;
    chk("lsw_rsp_ready", lsu_rsp_ready, 1);
    chk("lsw_cycle_pre", cycle_cnt, 4);
    rst_n = 0;
    #1;
    chk("lsw_rst_if_req", ifu_req_valid, 1);
    chk("lsw_rst_rsp_ready", lsu_rsp_ready, 0);
    chk("lsw_rst_cycle", cycle_cnt, 0);
    chk("lsw_rst_cycle4", w4_cycle_cnt, 0);
    cyc();
    rst_n = 1;

    // 16 ALU instructions: 4-bit counters wrap to 0
    for (int i = 0; i < 16; i++) alu_instr();
    chk("wrap_instret64", instret_cnt, 16);
    chk("wrap_cycle64", cycle_cnt, 64);
    chk("wrap_instret4", w4_instret_cnt, 0);
    chk("wrap_cycle4", w4_cycle_cnt, 0);

    // Illegal decode: load and store together
    fetch();
    dec_mem_ren = 1;
    dec_mem_wen = 1;
    cyc();
    clr();
    lsu_req_ready = 1;
    #1;
    chk("ill_trapped", trapped, 1);
    chk("ill_lsu_valid", lsu_req_valid, 0);
    chk("ill_cycle64", cycle_cnt, 67);
    chk("ill_cycle4", w4_cycle_cnt, 3);
    cyc();
    chk("ill_frozen", cycle_cnt, 67);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ysyx_25030081_seq.md
# ysyx_25030081_seq

Multi-cycle instruction sequencer for the RV32I core. Steps each instruction through fetch, execute, optional load/store, and writeback. Drives the instruction-fetch and load/store memory ports with valid/ready handshakes, and generates the register-file, PC and IR write strobes from the decoder's control outputs. Also maintains cycle and retired-instruction counters, and parks the core on `ebreak` or a bus error.

## Interface
- `CNT_W`, default 64: width of the cycle and instret counters.
- `clk` in 1: core clock.
- `rst_n` in 1: asynchronous active-low reset.
- `ifu_req_valid` out 1: fetch request to instruction memory.
- `ifu_req_ready` in 1: instruction memory accepts the request.
- `ifu_rsp_valid` in 1: fetched word is valid.
- `ifu_rsp_err` in 1: fetch access fault; qualified by `ifu_rsp_valid`.
- `ifu_rsp_ready` out 1: sequencer accepts the fetch response.
- `ir_we` out 1: load IR with the fetched word.
- `dec_mem_ren` in 1: decoded load; sampled in EX.
- `dec_mem_wen` in 1: decoded store; sampled in EX.
- `dec_reg_wr` in 1: decoded rd write; sampled in EX.
- `dec_ebreak` in 1: decoded `ebreak`; sampled in EX.
- `lsu_req_valid` out 1: load/store request.
- `lsu_req_wen` out 1: 1 = store, 0 = load; stable while `lsu_req_valid` is high.
- `lsu_req_ready` in 1: LSU accepts the request.
- `lsu_rsp_valid` in 1: LSU response valid.
- `lsu_rsp_err` in 1: LSU access fault.
- `lsu_rsp_ready` out 1: sequencer accepts the LSU response.
- `rf_we` out 1: register-file write strobe.
- `pc_we` out 1: PC update strobe (next PC from the datapath).
- `halted` out 1: sticky, set by `ebreak`.
- `trapped` out 1: sticky, set by a bus error or illegal decode.
- `cycle_cnt` out CNT_W: count of active cycles.
- `instret_cnt` out CNT_W: count of retired instructions.

## Operation
- States: IF_REQ, IF_WAIT, EX, LS_REQ, LS_WAIT, WB, HALT, TRAP.
- IF_REQ:
  - `ifu_req_valid`=1.
  - `ifu_req_ready`=1 → IF_WAIT; otherwise stay.
- IF_WAIT:
  - `ifu_rsp_ready`=1.
  - On `ifu_rsp_valid` with err=0: `ir_we`=1 that cycle → EX.
  - On `ifu_rsp_valid` with err=1: no `ir_we` → TRAP.
- EX (exactly one cycle):
  - Latch `dec_*` into `mem_ren_q`, `mem_wen_q`, `reg_wr_q`.
  - Priority: `dec_ebreak` → HALT; `dec_mem_ren`&`dec_mem_wen` → TRAP; `dec_mem_ren`|`dec_mem_wen` → LS_REQ; else → WB.
- LS_REQ:
  - `lsu_req_valid`=1, `lsu_req_wen`=`mem_wen_q`.
  - `lsu_req_ready` → LS_WAIT.
- LS_WAIT:
  - `lsu_rsp_ready`=1.
  - `lsu_rsp_valid`&!err → WB; `lsu_rsp_valid`&err → TRAP.
- WB (one cycle):
  - `rf_we`=`reg_wr_q`, `pc_we`=1, instret+1 → IF_REQ.
- HALT/TRAP: absorbing until reset. All request, ready and strobe outputs are 0.
- Handshake rules:
  - A valid, once raised, stays high until its ready is seen. No combinational path from ready to valid.
  - Responses arriving in any state other than the matching WAIT state are ignored.
- Counters:
  - `cycle_cnt` increments every cycle the state is not HALT/TRAP.
  - `instret_cnt` increments in WB.
  - Both wrap from 2^CNT_W−1 to 0 silently.
  - Both freeze in HALT/TRAP.

## Timing
- All outputs are Moore (decoded from the state register), except `ir_we`, which is IF_WAIT & `ifu_rsp_valid` & !`ifu_rsp_err`.
- Reset values:
  - State = IF_REQ.
  - Counters = 0, `halted`=`trapped`=0, latched `dec_*` regs = 0.
  - All strobes = 0, with one exception: `ifu_req_valid`=1 while in reset-released IF_REQ.
- Reset asserted mid-transaction: immediate return to IF_REQ. Outstanding bus responses are not tracked; the memory model must be reset together with the core.
- Minimum per-instruction latency with zero-wait memories:
  - ALU instruction: 4 cycles (IF_REQ, IF_WAIT, EX, WB).
  - Load/store: 6 cycles.
- Request and response in the same cycle: the accepting edge moves to the WAIT state. The response is only sampled from the WAIT state, so a memory must present its response no earlier than the cycle after acceptance.

## Structure
- Shared package holds:
  - State enum, 3-bit encoding.
  - `CNT_W` default constant.
- One sub-module, `ysyx_25030081_perf_cnt` (enable, width parameter, async clear), instantiated twice for `cycle_cnt` and `instret_cnt`.
- The FSM and strobe decode live in this block.

## Test plan
- **Zero-wait ADD** (`dec_reg_wr`=1, no mem):
  - `ir_we` in cycle 2; `rf_we`=`pc_we`=1 in cycle 4.
  - `instret_cnt`=1 and `cycle_cnt`=4 after cycle 4.
- **LW with `lsu_req_ready` delayed 3 cycles and response delayed 2**:
  - `lsu_req_valid` held for 4 cycles; `lsu_req_wen`=0.
  - Total 11 cycles; `rf_we`=1 in WB.
- **SW** (`dec_mem_wen`=1, `dec_reg_wr`=0):
  - `lsu_req_wen`=1, `rf_we`=0, `pc_we`=1 in WB.
- **`ifu_rsp_err`=1**:
  - No `ir_we`; `trapped`=1 next cycle.
  - Counters frozen; valids stay 0 for 20 cycles.
- **`dec_ebreak` in EX**:
  - `halted`=1; `pc_we` never asserts; spurious `lsu_rsp_valid` is ignored.
- **Reset pulse in LS_WAIT, and counter wrap**:
  - After the reset pulse, state returns to IF_REQ with counters at 0.
  - With `CNT_W`=4, 16 ALU instructions leave `instret_cnt`=0.
